// File: rtl/param_shift_reg_if.sv
// Bus bundle for param_shift_reg: control, serial/parallel data in, and all
// observed stage outputs. The master drives control/data; the slave is the register.
interface param_shift_reg_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);

    logic                   clr;
    logic                   en;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       din;
    logic [WIDTH-1:0]       din_rev;
    logic [WIDTH*DEPTH-1:0] load_data;
    logic [SW-1:0]          tap_sel;

    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       q_rev;
    logic [WIDTH-1:0]       tap;
    logic [WIDTH*DEPTH-1:0] par_out;
    logic [FW-1:0]          fill;
    logic                   full;

    modport master (
        output clr, en, mode, din, din_rev, load_data, tap_sel,
        input  q, q_rev, tap, par_out, fill, full
    );

    modport slave (
        input  clr, en, mode, din, din_rev, load_data, tap_sel,
        output q, q_rev, tap, par_out, fill, full
    );
endinterface

// File: rtl/param_shift_reg.sv
// Bidirectional shift register with parallel load, selectable tap and a
// saturating fill counter. Outputs come straight from the stage registers.
module param_shift_reg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    param_shift_reg_if.slave   bus
);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_FWD  = 2'b01;
    localparam logic [1:0] MODE_BWD  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [WIDTH-1:0]       s_reg  [DEPTH];
    logic [WIDTH-1:0]       s_next [DEPTH];
    logic [FW-1:0]          fill_reg;
    logic [FW-1:0]          fill_next;
    logic [WIDTH*DEPTH-1:0] par_flat;
    logic [WIDTH-1:0]       tap_mux;
    logic [FW-1:0]          fill_inc;

    // Fill only counts up to DEPTH; extra shifts still move data.
    assign fill_inc = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + FW'(1);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            s_next[i] = s_reg[i];
        end
        fill_next = fill_reg;

        if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_next[i] = '0;
            end
            fill_next = '0;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_FWD: begin
                    s_next[0] = bus.din;
                    for (int i = 1; i < DEPTH; i++) begin
                        s_next[i] = s_reg[i-1];
                    end
                    fill_next = fill_inc;
                end
                MODE_BWD: begin
                    s_next[DEPTH-1] = bus.din_rev;
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        s_next[i] = s_reg[i+1];
                    end
                    fill_next = fill_inc;
                end
                MODE_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        s_next[i] = bus.load_data[i*WIDTH +: WIDTH];
                    end
                    fill_next = FILL_MAX;
                end
                default: begin
                    fill_next = fill_reg;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_reg[i] <= '0;
            end
            fill_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                s_reg[i] <= s_next[i];
            end
            fill_reg <= fill_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pack
            assign par_flat[gi*WIDTH +: WIDTH] = s_reg[gi];
        end
    endgenerate

    // Selects beyond the last stage (non-power-of-two DEPTH) read as zero.
    always_comb begin
        tap_mux = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(bus.tap_sel) == i) begin
                tap_mux = s_reg[i];
            end
        end
    end

    assign bus.q       = s_reg[DEPTH-1];
    assign bus.q_rev   = s_reg[0];
    assign bus.tap     = tap_mux;
    assign bus.par_out = par_flat;
    assign bus.fill    = fill_reg;
    assign bus.full    = (fill_reg == FILL_MAX);
endmodule

// File: tb/tb_param_shift_reg.sv
// Self-checking bench for param_shift_reg: vector table, hand sequences for
// latency/tap/reset corners, and randomized traffic against a packed-word model.
module tb_param_shift_reg;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    param_shift_reg_if #(.WIDTH(1), .DEPTH(3)) ifa ();
    param_shift_reg_if #(.WIDTH(8), .DEPTH(4)) ifb ();
    param_shift_reg_if #(.WIDTH(8), .DEPTH(5)) ifc ();

    param_shift_reg #(.WIDTH(1), .DEPTH(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    param_shift_reg #(.WIDTH(8), .DEPTH(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    param_shift_reg #(.WIDTH(8), .DEPTH(5)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    typedef struct {
        logic        clr;
        logic        en;
        logic [1:0]  mode;
        logic [7:0]  din;
        logic [7:0]  din_rev;
        logic [31:0] load;
        logic [31:0] exp_par;
        int          exp_fill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [39:0] model_par;
        int          model_fill;
        logic [2:0]  seq_a;
        int          ts;
        logic [7:0]  exp_tap;

        rst_n = 1'b0;
        {ifa.clr, ifa.en, ifa.mode, ifa.din, ifa.din_rev, ifa.load_data, ifa.tap_sel} = '0;
        {ifb.clr, ifb.en, ifb.mode, ifb.din, ifb.din_rev, ifb.load_data, ifb.tap_sel} = '0;
        {ifc.clr, ifc.en, ifc.mode, ifc.din, ifc.din_rev, ifc.load_data, ifc.tap_sel} = '0;
        #12;
        check("reset a par", ifa.par_out, 0);
        check("reset b par", ifb.par_out, 0);
        check("reset c par", ifc.par_out, 0);
        check("reset c fill", ifc.fill, 0);
        check("reset c full", ifc.full, 0);
        rst_n = 1'b1;
        tick();

        // {clr, en, mode, din, din_rev, load, exp_par, exp_fill}
        vecs.push_back('{1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 32'h44332211, 32'h44332211, 4});
        vecs.push_back('{1'b0, 1'b1, 2'b10, 8'h00, 8'hAA, 32'h0,        32'hAA443322, 4});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 8'h55, 8'h00, 32'h0,        32'h44332255, 4});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 8'h66, 8'h77, 32'h0,        32'h44332255, 4});
        vecs.push_back('{1'b0, 1'b0, 2'b11, 8'h00, 8'h00, 32'h12345678, 32'h44332255, 4});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 8'h00, 8'h00, 32'h12345678, 32'h00000000, 0});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 8'h01, 8'h00, 32'h0,        32'h00000001, 1});
        vecs.push_back('{1'b0, 1'b0, 2'b01, 8'h02, 8'h00, 32'h0,        32'h00000001, 1});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 8'h03, 8'h00, 32'h0,        32'h00000103, 2});
        vecs.push_back('{1'b0, 1'b0, 2'b01, 8'h04, 8'h00, 32'h0,        32'h00000103, 2});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 8'h05, 8'h00, 32'h0,        32'h00010305, 3});
        vecs.push_back('{1'b0, 1'b1, 2'b10, 8'h00, 8'h09, 32'h0,        32'h09000103, 4});
        vecs.push_back('{1'b0, 1'b1, 2'b10, 8'h00, 8'h0A, 32'h0,        32'h0A090001, 4});
        vecs.push_back('{1'b1, 1'b1, 2'b01, 8'hFF, 8'h00, 32'h0,        32'h00000000, 0});
        vecs.push_back('{1'b0, 1'b1, 2'b10, 8'h00, 8'h77, 32'h0,        32'h77000000, 1});

        foreach (vecs[i]) begin
            ifb.clr       = vecs[i].clr;
            ifb.en        = vecs[i].en;
            ifb.mode      = vecs[i].mode;
            ifb.din       = vecs[i].din;
            ifb.din_rev   = vecs[i].din_rev;
            ifb.load_data = vecs[i].load;
            tick();
            check($sformatf("vec%0d par_out", i), ifb.par_out, vecs[i].exp_par);
            check($sformatf("vec%0d q", i), ifb.q, vecs[i].exp_par[31:24]);
            check($sformatf("vec%0d q_rev", i), ifb.q_rev, vecs[i].exp_par[7:0]);
            check($sformatf("vec%0d fill", i), ifb.fill, vecs[i].exp_fill);
            check($sformatf("vec%0d full", i), ifb.full, vecs[i].exp_fill == 4);
            $display("vec%0d clr=%0b en=%0b mode=%0d par_out=%08h fill=%0d",
                     i, vecs[i].clr, vecs[i].en, vecs[i].mode, ifb.par_out, ifb.fill);
        end
        ifb.en  = 1'b0;
        ifb.clr = 1'b0;

        // Serial latency on the 1-bit, 3-deep instance
        seq_a    = 3'b101;
        ifa.en   = 1'b1;
        ifa.mode = 2'b01;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("lat full before edge%0d", k + 1), ifa.full, 0);
            ifa.din = seq_a[k];
            tick();
            check($sformatf("lat fill edge%0d", k + 1), ifa.fill, k + 1);
            $display("latency edge%0d din=%0b q=%0b fill=%0d", k + 1, seq_a[k], ifa.q, ifa.fill);
        end
        check("lat q", ifa.q, 1);
        check("lat full", ifa.full, 1);
        check("lat par_out", ifa.par_out, 3'b101);
        ifa.en = 1'b0;

        // Tap sweep including out-of-range selects
        ifc.en        = 1'b1;
        ifc.mode      = 2'b11;
        ifc.load_data = 40'h5544332211;
        tick();
        ifc.en = 1'b0;
        for (int t = 0; t < 8; t++) begin
            ifc.tap_sel = 3'(t);
            #1;
            exp_tap = (t < 5) ? 8'((t + 1) * 17) : 8'h00;
            check($sformatf("tap_sel=%0d", t), ifc.tap, exp_tap);
            $display("tap_sel=%0d tap=%02h", t, ifc.tap);
        end

        // Randomized traffic against a packed-word model
        model_par  = 40'h5544332211;
        model_fill = 5;
        for (int n = 0; n < 300; n++) begin
            ifc.clr       = ($urandom_range(0, 15) == 0);
            ifc.en        = ($urandom_range(0, 3) != 0);
            ifc.mode      = 2'($urandom_range(0, 3));
            ifc.din       = 8'($urandom);
            ifc.din_rev   = 8'($urandom);
            ifc.load_data = {8'($urandom), 32'($urandom)};
            ifc.tap_sel   = 3'($urandom_range(0, 7));
            if (ifc.clr) begin
                model_par  = '0;
                model_fill = 0;
            end else if (ifc.en) begin
                case (ifc.mode)
                    2'b01: begin
                        model_par  = {model_par[31:0], ifc.din};
                        model_fill = (model_fill < 5) ? model_fill + 1 : 5;
                    end
                    2'b10: begin
                        model_par  = {ifc.din_rev, model_par[39:8]};
                        model_fill = (model_fill < 5) ? model_fill + 1 : 5;
                    end
                    2'b11: begin
                        model_par  = ifc.load_data;
                        model_fill = 5;
                    end
                    default: ;
                endcase
            end
            tick();
            ts      = int'(ifc.tap_sel);
            exp_tap = (ts < 5) ? model_par[ts*8 +: 8] : 8'h00;
            check($sformatf("rnd%0d par_out", n), ifc.par_out, model_par);
            check($sformatf("rnd%0d q", n), ifc.q, model_par[39:32]);
            check($sformatf("rnd%0d q_rev", n), ifc.q_rev, model_par[7:0]);
            check($sformatf("rnd%0d tap", n), ifc.tap, exp_tap);
            check($sformatf("rnd%0d fill", n), ifc.fill, model_fill);
            check($sformatf("rnd%0d full", n), ifc.full, model_fill == 5);
            $display("rnd%0d clr=%0b en=%0b mode=%0d par_out=%010h fill=%0d",
                     n, ifc.clr, ifc.en, ifc.mode, ifc.par_out, ifc.fill);
        end

        // Asynchronous reset pulse between edges mid-shift
        ifc.clr     = 1'b0;
        ifc.en      = 1'b1;
        ifc.mode    = 2'b01;
        ifc.din     = 8'hC3;
        ifc.tap_sel = 3'd0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async par_out", ifc.par_out, 0);
        check("async q", ifc.q, 0);
        check("async q_rev", ifc.q_rev, 0);
        check("async tap", ifc.tap, 0);
        check("async fill", ifc.fill, 0);
        check("async full", ifc.full, 0);
        #1;
        rst_n = 1'b1;
        tick();
        check("post-reset fill", ifc.fill, 1);
        check("post-reset par_out", ifc.par_out, 40'h00000000C3);
        $display("reset pulse: fill=%0d par_out=%010h", ifc.fill, ifc.par_out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
